// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// The FETCH_CTRL_PERF_EN macro enables the optional performance counters in fetch_ctrl.
package fetch_ctrl_pkg;

    localparam int PC_WIDTH   = 16;
    localparam int INST_WIDTH = 16;
    localparam int CNT_WIDTH  = 16;

    localparam logic [3:0] OPCODE_B   = 4'hC;
    localparam logic [3:0] OPCODE_BR  = 4'hD;
    localparam logic [3:0] OPCODE_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN,
        ST_HALT_PEND,
        ST_HALTED
    } fetch_state_t;

    function automatic logic is_halt(input logic [INST_WIDTH-1:0] i);
        return i[INST_WIDTH-1 -: 4] == OPCODE_HLT;
    endfunction

    // Instructions are halfword aligned; bit 0 of any target is dropped.
    function automatic logic [PC_WIDTH-1:0] pc_align(input logic [PC_WIDTH-1:0] a);
        return a & ~PC_WIDTH'(1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_buf.sv
// Single-entry instruction/PC buffer between fetch and decode.
// clear wins over load so a flush can never be overridden by a same-cycle fill.
module fetch_buf
    import fetch_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [INST_WIDTH-1:0] load_inst,
    input  logic [PC_WIDTH-1:0]   load_pc,
    output logic                  valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            inst    <= '0;
            inst_pc <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            inst    <= load_inst;
            inst_pc <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, single-entry decode buffer,
// redirect/squash handling and HLT stop. Define FETCH_CTRL_PERF_EN for fetch/squash counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_valid,
    input  logic [INST_WIDTH-1:0] imem_data,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    input  logic                  inst_ready,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [PC_WIDTH-1:0]   pc,
`ifdef FETCH_CTRL_PERF_EN
    output logic [CNT_WIDTH-1:0]  perf_fetch_cnt,
    output logic [CNT_WIDTH-1:0]  perf_squash_cnt,
`endif
    output logic                  halted
);

    fetch_state_t state, state_nxt;

    logic hs_req, hs_dec, redir;
    logic buf_load, buf_clear, pc_set, pc_inc;

    assign hs_req = imem_req && imem_ready;
    assign hs_dec = inst_valid && inst_ready;
    assign redir  = redirect && (state != ST_HALTED);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_REQ;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_REQ: begin
                if (hs_req) state_nxt = redirect ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect)        state_nxt = imem_valid ? ST_REQ : ST_DRAIN;
                else if (imem_valid) state_nxt = is_halt(imem_data) ? ST_HALT_PEND : ST_HOLD;
            end
            ST_HOLD: begin
                if (redirect || hs_dec) state_nxt = ST_REQ;
            end
            // A redirect landing with the awaited response still closes the drain:
            // nothing is outstanding any more.
            ST_DRAIN: begin
                if (imem_valid) state_nxt = ST_REQ;
            end
            ST_HALT_PEND: begin
                if (redirect)    state_nxt = ST_REQ;
                else if (hs_dec) state_nxt = ST_HALTED;
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_REQ;
        endcase
    end

    always_comb begin
        imem_req  = (state == ST_REQ);
        halted    = (state == ST_HALTED);
        buf_load  = (state == ST_WAIT) && imem_valid && !redirect;
        buf_clear = redir || (hs_dec && (state == ST_HOLD || state == ST_HALT_PEND));
        pc_set    = redir;
        pc_inc    = hs_req && !redirect;
    end

    always_ff @(posedge clk) begin
        if (rst)         pc <= '0;
        else if (pc_set) pc <= pc_align(redirect_pc);
        else if (pc_inc) pc <= pc + PC_WIDTH'(2);
    end

    assign imem_addr = pc;

    // pc already advanced past the accepted request, so the fetched address is pc-2.
    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_inst (imem_data),
        .load_pc   (pc - PC_WIDTH'(2)),
        .valid     (inst_valid),
        .inst      (inst),
        .inst_pc   (inst_pc)
    );

`ifdef FETCH_CTRL_PERF_EN
    logic squash_evt;

    assign squash_evt = ((state == ST_DRAIN) && imem_valid) ||
                        ((state == ST_WAIT) && imem_valid && redirect) ||
                        (redir && inst_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt  <= '0;
            perf_squash_cnt <= '0;
        end else begin
            if (hs_dec && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + CNT_WIDTH'(1);
            if (squash_evt && perf_squash_cnt != '1)
                perf_squash_cnt <= perf_squash_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus pushes expected requests/decodes,
// a negedge monitor pops and compares on every handshake.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc;
    logic        halted;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_squash_cnt;
`endif

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
`ifdef FETCH_CTRL_PERF_EN
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_squash_cnt (perf_squash_cnt),
`endif
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] pc;
    } dec_t;

    logic [15:0] exp_req_q[$];
    dec_t        exp_dec_q[$];
    dec_t        mon_d;
    int          checks   = 0;
    int          failures = 0;

    int          lat         = 1;
    logic        force_valid = 1'b0;
    logic        zero_data   = 1'b1;
    logic [15:0] hlt_addr    = 16'hFFFF;
    int          resp_cnt    = 0;
    logic [15:0] resp_addr   = 16'h0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        if (zero_data)     return 16'h0000;
        if (a == hlt_addr) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    function automatic dec_t mk(input logic [15:0] i, input logic [15:0] p);
        dec_t d;
        d.inst = i;
        d.pc   = p;
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((exp_req_q.size() != 0 || exp_dec_q.size() != 0) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_req_q.size() != 0 || exp_dec_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual=req%0d/dec%0d_pending expected=0/0",
                     nm, exp_req_q.size(), exp_dec_q.size());
            exp_req_q.delete();
            exp_dec_q.delete();
        end
    endtask

    // Memory model: answers each accepted request after lat cycles; force_valid injects a stray pulse.
    initial begin
        imem_valid = 1'b0;
        imem_data  = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst && imem_req && imem_ready) begin
                resp_cnt  = lat;
                resp_addr = imem_addr;
            end
            @(posedge clk);
            #2;
            imem_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_data  = memf(resp_addr);
                end
            end
            if (force_valid) begin
                imem_valid = 1'b1;
                imem_data  = 16'h1EEE;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && imem_req && imem_ready) begin
            if (exp_req_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL req_unexpected actual=%h expected=none", imem_addr);
            end else begin
                chk("req_addr", 32'(imem_addr), 32'(exp_req_q.pop_front()));
            end
        end
        if (!rst && inst_valid && inst_ready) begin
            if (exp_dec_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dec_unexpected actual=%h@%h expected=none", inst, inst_pc);
            end else begin
                mon_d = exp_dec_q.pop_front();
                chk("dec_inst_pc", {inst, inst_pc}, {mon_d.inst, mon_d.pc});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_ready = 1'b0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 16'h0;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_addr", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0000});
        chk("rst_pc_halted", {15'h0, halted, pc}, 32'h0);
        chk("rst_buf", {15'h0, inst_valid, inst}, 32'h0);
        chk("rst_inst_pc", 32'(inst_pc), 32'h0);

        // Sequential fetch of zero words.
        exp_req_q.push_back(16'h0000); exp_req_q.push_back(16'h0002); exp_req_q.push_back(16'h0004);
        exp_dec_q.push_back(mk(16'h0, 16'h0000));
        exp_dec_q.push_back(mk(16'h0, 16'h0002));
        exp_dec_q.push_back(mk(16'h0, 16'h0004));
        cyc(); imem_ready = 1'b1; inst_ready = 1'b1;
        wait_drain("seq");
        cyc(); imem_ready = 1'b0;
        @(negedge clk);
        chk("seq_pc", 32'(pc), 32'h0006);

        // Odd redirect target while unaccepted, then wrap at 0xFFFE.
        zero_data = 1'b0;
        cyc(); redirect = 1'b1; redirect_pc = 16'hFFFF;
        cyc(); redirect = 1'b0;
        @(negedge clk);
        chk("redir_req_addr", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'hFFFE});
        exp_req_q.push_back(16'hFFFE); exp_req_q.push_back(16'h0000);
        exp_dec_q.push_back(mk(16'h1FFE, 16'hFFFE));
        exp_dec_q.push_back(mk(16'h1000, 16'h0000));
        cyc(); imem_ready = 1'b1;
        wait_drain("wrap");
        cyc(); imem_ready = 1'b0;
        @(negedge clk);
        chk("wrap_pc", 32'(pc), 32'h0002);

        // Redirect during WAIT with slow memory: response drained.
        exp_req_q.push_back(16'h0002); exp_req_q.push_back(16'h0040);
        exp_dec_q.push_back(mk(16'h1040, 16'h0040));
        lat = 3;
        cyc(); imem_ready = 1'b1;
        cyc(); redirect = 1'b1; redirect_pc = 16'h0040;
        cyc(); redirect = 1'b0; lat = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_no_stale", 32'(inst_valid), 32'h0);
            cyc();
        end
        wait_drain("drain");
        cyc(); imem_ready = 1'b0;

        // Redirect coinciding with the response in WAIT.
        exp_req_q.push_back(16'h0042); exp_req_q.push_back(16'h0080);
        exp_dec_q.push_back(mk(16'h1080, 16'h0080));
        cyc(); imem_ready = 1'b1;
        cyc(); redirect = 1'b1; redirect_pc = 16'h0080;
        cyc(); redirect = 1'b0;
        @(negedge clk);
        chk("wait_redir_no_stale", 32'(inst_valid), 32'h0);
        wait_drain("wait_redir");
        cyc(); imem_ready = 1'b0;

        // Redirect coinciding with the request handshake.
        exp_req_q.push_back(16'h0082); exp_req_q.push_back(16'h00A0);
        exp_dec_q.push_back(mk(16'h10A0, 16'h00A0));
        cyc(); imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h00A0;
        cyc(); redirect = 1'b0;
        wait_drain("req_redir");
        cyc(); imem_ready = 1'b0;
        @(negedge clk);
        chk("req_redir_pc", 32'(pc), 32'h00A2);
`ifdef FETCH_CTRL_PERF_EN
        chk("perf_squash", 32'(perf_squash_cnt), 32'd3);
        chk("perf_fetch", 32'(perf_fetch_cnt), 32'd8);
`endif

        // Decode stall in HOLD for 10 cycles.
        inst_ready = 1'b0;
        exp_req_q.push_back(16'h00A2);
        cyc(); imem_ready = 1'b1;
        cyc(); imem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_data", {inst, inst_pc}, {16'h10A2, 16'h00A2});
            chk("hold_vld_req", {30'h0, inst_valid, imem_req}, 32'h2);
            cyc();
        end
        exp_dec_q.push_back(mk(16'h10A2, 16'h00A2));
        inst_ready = 1'b1;
        wait_drain("hold_release");
        cyc();
`ifdef FETCH_CTRL_PERF_EN
        @(negedge clk);
        chk("perf_fetch_release", 32'(perf_fetch_cnt), 32'd9);
`endif

        // HLT waiting in HALT_PEND, redirected away.
        inst_ready = 1'b0; hlt_addr = 16'h00A4;
        exp_req_q.push_back(16'h00A4);
        cyc(); imem_ready = 1'b1;
        cyc(); imem_ready = 1'b0;
        cyc();
        @(negedge clk);
        chk("hltpend_buf", {inst, inst_pc}, {16'hF000, 16'h00A4});
        chk("hltpend_flags", {29'h0, halted, imem_req, inst_valid}, 32'h1);
        cyc(); redirect = 1'b1; redirect_pc = 16'h0100;
        cyc(); redirect = 1'b0;
        @(negedge clk);
        chk("hltpend_redir", {13'h0, halted, imem_req, inst_valid, imem_addr}, {13'h0, 3'b010, 16'h0100});

        // HLT retires: halted for 100 cycles, everything ignored.
        cyc(); redirect = 1'b1; redirect_pc = 16'h0010;
        cyc(); redirect = 1'b0;
        hlt_addr = 16'h0010;
        exp_req_q.push_back(16'h0010);
        exp_dec_q.push_back(mk(16'hF000, 16'h0010));
        inst_ready = 1'b1; imem_ready = 1'b1;
        wait_drain("halt");
        for (int i = 0; i < 100; i++) begin
            cyc();
            redirect    = (i == 10);
            redirect_pc = 16'h0200;
            force_valid = (i == 20);
            @(negedge clk);
            chk("halted_state", {13'h0, halted, imem_req, inst_valid, pc}, {13'h0, 3'b100, 16'h0012});
        end
        cyc(); redirect = 1'b0; force_valid = 1'b0; imem_ready = 1'b0;

        // Reset mid-transaction; the late response must be ignored.
        rst = 1'b1;
        cyc(); cyc(); rst = 1'b0;
        @(negedge clk);
        chk("rst2_state", {15'h0, halted, pc}, 32'h0);
`ifdef FETCH_CTRL_PERF_EN
        chk("rst2_perf", {perf_fetch_cnt, perf_squash_cnt}, 32'h0);
`endif
        lat = 3;
        exp_req_q.push_back(16'h0000);
        cyc(); imem_ready = 1'b1;
        cyc(); rst = 1'b1; imem_ready = 1'b0;
        cyc(); rst = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("late_valid_ignored", {14'h0, imem_req, inst_valid, imem_addr}, {14'h0, 2'b10, 16'h0000});
        lat = 1;
        exp_req_q.push_back(16'h0000);
        exp_dec_q.push_back(mk(16'h1000, 16'h0000));
        cyc(); imem_ready = 1'b1;
        wait_drain("post_rst");
        cyc(); imem_ready = 1'b0;

        @(negedge clk);
        chk("queues_empty", 32'(exp_req_q.size() + exp_dec_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
